// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared constants, types and coordinate clamp for the bicubic window fetcher
package bicubic_pkg;
  localparam int IMG_W   = 100;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 8;
  localparam int WIN     = 4;
  localparam int WIN_PIX = WIN * WIN;

  typedef logic [DATA_W-1:0] pix_t;
  typedef pix_t [WIN_PIX-1:0] win_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Neighbour offset is off-1 (range -1..+2); result clamped to [0, size-1].
  function automatic logic [4:0] clamp_coord(input logic [4:0] base,
                                             input logic [1:0] off,
                                             input logic [4:0] size);
    logic signed [6:0] v;
    logic signed [6:0] hi;
    v  = $signed({2'b00, base}) + $signed({5'b00000, off}) - 7'sd1;
    hi = (size == 5'd0) ? 7'sd0 : $signed({2'b00, size}) - 7'sd1;
    if (v < 7'sd0) begin
      v = 7'sd0;
    end else if (v > hi) begin
      v = hi;
    end
    return v[4:0];
  endfunction
endpackage

// File: rtl/bicubic_win_fetch_if.sv
// rtl/bicubic_win_fetch_if.sv - request, ROM and window handshake bundle
interface bicubic_win_fetch_if #(
  parameter int ADDR_W = bicubic_pkg::ADDR_W,
  parameter int DATA_W = bicubic_pkg::DATA_W
);
  logic                                    req_valid;
  logic                                    req_ready;
  logic [4:0]                              req_x;
  logic [4:0]                              req_y;
  logic                                    rom_rd;
  logic [ADDR_W-1:0]                       rom_addr;
  logic [DATA_W-1:0]                       rom_q;
  logic                                    win_valid;
  logic                                    win_ready;
  logic [bicubic_pkg::WIN_PIX*DATA_W-1:0]  win_data;

  modport master (
    output req_valid, req_x, req_y, rom_q, win_ready,
    input  req_ready, rom_rd, rom_addr, win_valid, win_data
  );

  modport slave (
    input  req_valid, req_x, req_y, rom_q, win_ready,
    output req_ready, rom_rd, rom_addr, win_valid, win_data
  );
endinterface

// File: rtl/bicubic_addr_gen.sv
// rtl/bicubic_addr_gen.sv - clamps one 4x4 neighbour to the ROI and forms its ROM address
module bicubic_addr_gen #(
  parameter int IMG_W  = bicubic_pkg::IMG_W,
  parameter int ADDR_W = bicubic_pkg::ADDR_W
) (
  input  logic [6:0]        i_h0,
  input  logic [6:0]        i_v0,
  input  logic [4:0]        i_sw,
  input  logic [4:0]        i_sh,
  input  logic [4:0]        i_x,
  input  logic [4:0]        i_y,
  input  logic [1:0]        i_c,
  input  logic [1:0]        i_r,
  output logic [ADDR_W-1:0] o_addr
);
  import bicubic_pkg::*;

  logic [4:0]        w_cx;
  logic [4:0]        w_cy;
  logic [ADDR_W-1:0] w_row;

  assign w_cx   = clamp_coord(i_x, i_c, i_sw);
  assign w_cy   = clamp_coord(i_y, i_r, i_sh);
  assign w_row  = ADDR_W'(i_v0) + ADDR_W'(w_cy);
  assign o_addr = w_row * ADDR_W'(IMG_W) + ADDR_W'(i_h0) + ADDR_W'(w_cx);
endmodule

// File: rtl/bicubic_win_fetch.sv
// rtl/bicubic_win_fetch.sv - 4x4 source window fetcher for the bicubic resizer
// Column reuse on x+1 steps is built only when FETCH_REUSE_EN is defined.
module bicubic_win_fetch #(
  parameter int IMG_W  = bicubic_pkg::IMG_W,
  parameter int ADDR_W = bicubic_pkg::ADDR_W,
  parameter int DATA_W = bicubic_pkg::DATA_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [6:0]         i_h0,
  input  logic [6:0]         i_v0,
  input  logic [4:0]         i_sw,
  input  logic [4:0]         i_sh,
  input  logic               i_flush,
  bicubic_win_fetch_if.slave bus
);
  import bicubic_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_idx;
  logic [3:0]        r_idx_d;
  logic              r_rd_d;
  logic [4:0]        r_x;
  logic [4:0]        r_y;
  logic [DATA_W-1:0] r_win [WIN_PIX];
  logic              w_accept;
  logic              w_reuse;
  logic              w_req_ready;
  logic              w_rom_rd;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept = w_req_ready && bus.req_valid;

`ifdef FETCH_REUSE_EN
  logic       r_hist_valid;
  logic [4:0] r_last_x;
  logic [4:0] r_last_y;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist_valid <= 1'b0;
      r_last_x     <= 5'd0;
      r_last_y     <= 5'd0;
    end else if (i_flush) begin
      r_hist_valid <= 1'b0;
    end else if (r_state == ST_OUT && bus.win_ready) begin
      r_hist_valid <= 1'b1;
      r_last_x     <= r_x;
      r_last_y     <= r_y;
    end
  end

  // A flush coinciding with the accept must force a full fetch.
  assign w_reuse = r_hist_valid && !i_flush && (bus.req_y == r_last_y) &&
                   ({1'b0, bus.req_x} == ({1'b0, r_last_x} + 6'd1));
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_reuse        = 1'b0;
`endif

  bicubic_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_h0   (i_h0),
    .i_v0   (i_v0),
    .i_sw   (i_sw),
    .i_sh   (i_sh),
    .i_x    (r_x),
    .i_y    (r_y),
    .i_c    (r_idx[3:2]),
    .i_r    (r_idx[1:0]),
    .o_addr (w_addr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_FETCH;
      ST_FETCH: if (r_idx == 4'd15) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_OUT;
      ST_OUT:   if (bus.win_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // req_ready is gated by reset so every output reads 0 while held in reset.
  always_comb begin
    w_req_ready   = 1'b0;
    w_rom_rd      = 1'b0;
    bus.rom_addr  = '0;
    bus.win_valid = 1'b0;
    case (r_state)
      ST_IDLE:  w_req_ready = i_rst_n;
      ST_FETCH: begin
        w_rom_rd     = 1'b1;
        bus.rom_addr = w_addr;
      end
      ST_OUT:   bus.win_valid = 1'b1;
      default:  w_req_ready = 1'b0;
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rom_rd    = w_rom_rd;

  // Read k = 4c+r lands one cycle later at window slot 4r+c.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= 4'd0;
      r_idx_d <= 4'd0;
      r_rd_d  <= 1'b0;
      r_x     <= 5'd0;
      r_y     <= 5'd0;
      for (int i = 0; i < WIN_PIX; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      r_rd_d  <= w_rom_rd;
      r_idx_d <= r_idx;
      if (w_accept) begin
        r_x <= bus.req_x;
        r_y <= bus.req_y;
        if (w_reuse) begin
          r_idx <= 4'd12;
          for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN - 1; c++) begin
              r_win[WIN*r+c] <= r_win[WIN*r+c+1];
            end
          end
        end else begin
          r_idx <= 4'd0;
        end
      end else if (r_state == ST_FETCH) begin
        r_idx <= r_idx + 4'd1;
      end
      if (r_rd_d) begin
        r_win[{r_idx_d[1:0], r_idx_d[3:2]}] <= bus.rom_q;
      end
    end
  end

  for (genvar g = 0; g < WIN_PIX; g++) begin : g_win_out
    assign bus.win_data[g*DATA_W +: DATA_W] = r_win[g];
  end
endmodule

// File: tb/tb_bicubic_win_fetch.sv
// tb/tb_bicubic_win_fetch.sv - table-driven bench for bicubic_win_fetch with a synchronous ROM model
module tb_bicubic_win_fetch;
  import bicubic_pkg::*;

  localparam int H0 = 10;
  localparam int V0 = 20;
  localparam int SW = 8;
  localparam int SH = 8;
`ifdef FETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    bit flush_before;
    bit flush_same;
    bit reuse;
    int f_first;
    int f_last;
    int r_first;
    int r_last;
    int a00;
    int a33;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[8];
  vec_t after_rst;

  bicubic_win_fetch_if bus ();

  bicubic_win_fetch dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_h0    (7'(H0)),
    .i_v0    (7'(V0)),
    .i_sw    (5'(SW)),
    .i_sh    (5'(SH)),
    .i_flush (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int a);
    return 8'(a * 37 + (a >>> 8));
  endfunction

  always @(posedge clk) begin
    if (bus.rom_rd) bus.rom_q <= rom_f(int'(bus.rom_addr));
  end

  function automatic logic [127:0] exp_win(input int x, input int y);
    logic [127:0] w;
    int cx;
    int cy;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cx = x + c - 1;
        cy = y + r - 1;
        if (cx < 0) cx = 0;
        if (cx > SW - 1) cx = SW - 1;
        if (cy < 0) cy = 0;
        if (cy > SH - 1) cy = SH - 1;
        w[8*(4*r+c) +: 8] = rom_f((V0 + cy) * 100 + H0 + cx);
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int x, input int y, input bit fl);
    bus.req_x     = 5'(x);
    bus.req_y     = 5'(y);
    bus.req_valid = 1'b1;
    flush         = fl;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  nrd;
    int  first;
    int  last;
    int  lat;
    bit  ru;
    ru = v.reuse && REUSE;
    if (v.flush_before) begin
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    issue(v.x, v.y, v.flush_same);
    nrd = 0; first = -1; last = -1; lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.rom_rd) begin
        if (nrd == 0) first = int'(bus.rom_addr);
        last = int'(bus.rom_addr);
        nrd++;
      end
      if (bus.win_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_reads"},   128'(nrd),   128'(ru ? 4 : 16));
    check({tag, "_first"},   128'(first), 128'(ru ? v.r_first : v.f_first));
    check({tag, "_last"},    128'(last),  128'(ru ? v.r_last : v.f_last));
    check({tag, "_latency"}, 128'(lat),   128'(ru ? 5 : 17));
    check({tag, "_window"},  bus.win_data, exp_win(v.x, v.y));
    check({tag, "_p00"},     128'(bus.win_data[7:0]),     128'(rom_f(v.a00)));
    check({tag, "_p33"},     128'(bus.win_data[127:120]), 128'(rom_f(v.a33)));
    bus.win_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.win_ready = 1'b0;
    check({tag, "_idle_after"}, 128'({bus.req_ready, bus.win_valid}), 128'(2'b10));
  endtask

  initial begin
    logic [127:0] ew;
    int           nrd;
    bus.req_valid = 1'b0;
    bus.req_x     = 5'd0;
    bus.req_y     = 5'd0;
    bus.win_ready = 1'b0;

    vecs[0] = '{3, 3, 1'b0, 1'b0, 1'b0, 2212, 2515, 0,    0,    2212, 2515};
    vecs[1] = '{0, 0, 1'b0, 1'b0, 1'b0, 2010, 2212, 0,    0,    2010, 2212};
    vecs[2] = '{7, 7, 1'b0, 1'b0, 1'b0, 2616, 2717, 0,    0,    2616, 2717};
    vecs[3] = '{3, 3, 1'b0, 1'b0, 1'b0, 2212, 2515, 0,    0,    2212, 2515};
    vecs[4] = '{4, 3, 1'b0, 1'b0, 1'b1, 2213, 2516, 2216, 2516, 2213, 2516};
    vecs[5] = '{5, 3, 1'b1, 1'b0, 1'b0, 2214, 2517, 0,    0,    2214, 2517};
    vecs[6] = '{6, 3, 1'b0, 1'b0, 1'b1, 2215, 2517, 2217, 2517, 2215, 2517};
    vecs[7] = '{7, 3, 1'b0, 1'b1, 1'b0, 2216, 2517, 0,    0,    2216, 2517};
    after_rst = '{4, 3, 1'b0, 1'b0, 1'b0, 2213, 2516, 0, 0, 2213, 2516};

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_outputs", {bus.req_ready, bus.rom_rd, bus.win_valid, 14'(bus.rom_addr), bus.win_data != '0},
            '0);
    end
    rst_n = 1'b1;
    #1;
    check("reset_req_ready", 128'(bus.req_ready), 128'(1));
    nrd = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.rom_rd) nrd++;
    end
    check("idle_no_reads", 128'(nrd), 128'(0));

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    issue(3, 3, 1'b0);
    for (int n = 0; n < 17 && !bus.win_valid; n++) begin
      @(posedge clk);
      #1;
    end
    ew = exp_win(3, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_data", bus.win_data, ew);
      check("bp_ctrl", 128'({bus.win_valid, bus.req_ready, bus.rom_rd}), 128'(3'b100));
      @(posedge clk);
      #1;
    end
    bus.win_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.win_ready = 1'b0;
    check("bp_release", 128'({bus.req_ready, bus.win_valid}), 128'(2'b10));

    issue(3, 3, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("mid_fetch_busy", 128'(bus.rom_rd), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {bus.req_ready, bus.rom_rd, bus.win_valid, 14'(bus.rom_addr), bus.win_data != '0},
          '0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(after_rst, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
